// File: rtl/adder_arbiter.sv
// Round-robin arbiter that lets NUM_REQ requesters share one external adder.
// Granted operands are registered toward the adder and the sum is returned with its owner's id.
module adder_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 8,
  parameter int ADD_LAT = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable_in,
  input  logic [NUM_REQ-1:0]       req_in,
  input  logic [NUM_REQ*WIDTH-1:0] a_in,
  input  logic [NUM_REQ*WIDTH-1:0] b_in,
  output logic [NUM_REQ-1:0]       gnt_out,
  output logic [WIDTH-1:0]         add_a_out,
  output logic [WIDTH-1:0]         add_b_out,
  input  logic [WIDTH:0]           add_sum_in,
  output logic [NUM_REQ-1:0]       rsp_valid_out,
  output logic [2:0]               rsp_id_out,
  output logic [WIDTH:0]           rsp_sum_out,
  output logic                     busy_out
);

  logic [2:0]         r_ptr;
  logic [WIDTH-1:0]   r_add_a;
  logic [WIDTH-1:0]   r_add_b;
  logic [ADD_LAT:0]   r_tag_v;
  logic [2:0]         r_tag_id [ADD_LAT+1];
  logic [NUM_REQ-1:0] r_rsp_valid;
  logic [2:0]         r_rsp_id;
  logic [WIDTH:0]     r_rsp_sum;

  logic               w_found;
  logic [2:0]         w_win;
  logic [2:0]         w_ptr_nxt;
  logic [NUM_REQ-1:0] w_gnt;
  logic [WIDTH-1:0]   w_a;
  logic [WIDTH-1:0]   w_b;

  // Two passes: requesters at or above ptr first, then the wrapped-around ones below it.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_gnt   = '0;
    w_a     = '0;
    w_b     = '0;
    if (!rst && enable_in) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (!w_found && req_in[i] && (3'(i) >= r_ptr)) begin
          w_found  = 1'b1;
          w_win    = 3'(i);
          w_gnt[i] = 1'b1;
          w_a      = a_in[i*WIDTH +: WIDTH];
          w_b      = b_in[i*WIDTH +: WIDTH];
        end
      end
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (!w_found && req_in[i] && (3'(i) < r_ptr)) begin
          w_found  = 1'b1;
          w_win    = 3'(i);
          w_gnt[i] = 1'b1;
          w_a      = a_in[i*WIDTH +: WIDTH];
          w_b      = b_in[i*WIDTH +: WIDTH];
        end
      end
    end
  end

  assign w_ptr_nxt = (w_win == 3'(NUM_REQ-1)) ? '0 : w_win + 3'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr       <= '0;
      r_add_a     <= '0;
      r_add_b     <= '0;
      r_tag_v     <= '0;
      for (int unsigned i = 0; i <= ADD_LAT; i++) r_tag_id[i] <= '0;
      r_rsp_valid <= '0;
      r_rsp_id    <= '0;
      r_rsp_sum   <= '0;
    end else begin
      if (w_found) begin
        r_ptr   <= w_ptr_nxt;
        r_add_a <= w_a;
        r_add_b <= w_b;
      end
      r_tag_v     <= {r_tag_v[ADD_LAT-1:0], w_found};
      r_tag_id[0] <= w_win;
      for (int unsigned i = 1; i <= ADD_LAT; i++) r_tag_id[i] <= r_tag_id[i-1];
      if (r_tag_v[ADD_LAT]) begin
        r_rsp_valid <= NUM_REQ'(1) << r_tag_id[ADD_LAT];
        r_rsp_id    <= r_tag_id[ADD_LAT];
        r_rsp_sum   <= add_sum_in;
      end else begin
        r_rsp_valid <= '0;
      end
    end
  end

  assign gnt_out       = w_gnt;
  assign add_a_out     = r_add_a;
  assign add_b_out     = r_add_b;
  assign rsp_valid_out = r_rsp_valid;
  assign rsp_id_out    = r_rsp_id;
  assign rsp_sum_out   = r_rsp_sum;
  assign busy_out      = |r_tag_v;

endmodule

// File: tb/tb_adder_arbiter.sv
// Scoreboard bench for adder_arbiter with a one-cycle behavioural adder.
module tb_adder_arbiter;
  localparam int N = 4;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           en = 1'b0;
  logic [N-1:0]   req = '0;
  logic [N*W-1:0] a = '0;
  logic [N*W-1:0] b = '0;
  logic [N-1:0]   gnt;
  logic [W-1:0]   add_a;
  logic [W-1:0]   add_b;
  logic [W:0]     add_sum = '0;
  logic [N-1:0]   rsp_valid;
  logic [2:0]     rsp_id;
  logic [W:0]     rsp_sum;
  logic           busy;

  adder_arbiter #(.NUM_REQ(N), .WIDTH(W), .ADD_LAT(1)) dut (
    .clk(clk), .rst(rst), .enable_in(en), .req_in(req), .a_in(a), .b_in(b),
    .gnt_out(gnt), .add_a_out(add_a), .add_b_out(add_b), .add_sum_in(add_sum),
    .rsp_valid_out(rsp_valid), .rsp_id_out(rsp_id), .rsp_sum_out(rsp_sum),
    .busy_out(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) add_sum <= {1'b0, add_a} + {1'b0, add_b};

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {int id; int sum; int at;} exp_t;
  exp_t q[$];
  int checks = 0;
  int passed = 0;

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act == expv) passed++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
  endtask

  always @(negedge clk) begin
    if (rsp_valid != '0) begin
      if (q.size() == 0) begin
        checks++;
        $display("FAIL unexpected_rsp: got valid=%b id=%0d expected none (cycle %0d)",
                 rsp_valid, rsp_id, cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("rsp_valid", int'(rsp_valid), 1 << e.id);
        chk("rsp_id", int'(rsp_id), e.id);
        chk("rsp_sum", int'(rsp_sum), e.sum);
        chk("rsp_cycle", cyc, e.at);
      end
    end
  end

  // One cycle: drive inputs, check the grant; a granted op pushes its hand-computed result.
  task automatic step(input logic [N-1:0] r, input logic e, input logic [N-1:0] eg,
                      input int eid, input int esum, input bit push);
    exp_t x;
    @(negedge clk);
    req = r;
    en  = e;
    #1;
    chk("gnt", int'(gnt), int'(eg));
    if (push) begin
      x.id = eid; x.sum = esum; x.at = cyc + 3;
      q.push_back(x);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step('0, 1'b1, '0, 0, 0, 1'b0);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_gnt"}, int'(gnt), 0);
    chk({tag, "_add_a"}, int'(add_a), 0);
    chk({tag, "_add_b"}, int'(add_b), 0);
    chk({tag, "_rsp_valid"}, int'(rsp_valid), 0);
    chk({tag, "_rsp_id"}, int'(rsp_id), 0);
    chk({tag, "_rsp_sum"}, int'(rsp_sum), 0);
    chk({tag, "_busy"}, int'(busy), 0);
  endtask

  initial begin
    req = 4'b1111;
    en  = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check_zero("reset");
    @(negedge clk);
    rst = 1'b0;
    req = '0;

    // Fairness: sums are id0=11 id1=22 id2=33 id3=44.
    a = {8'd40, 8'd30, 8'd20, 8'd10};
    b = {8'd4, 8'd3, 8'd2, 8'd1};
    for (int k = 0; k < 8; k++)
      step(4'b1111, 1'b1, 4'(1 << (k % 4)), k % 4, 11 * ((k % 4) + 1), 1'b1);
    idle(4);

    // Single request, ptr back at 0.
    a = {8'd40, 8'd30, 8'd20, 8'd100};
    b = {8'd4, 8'd3, 8'd2, 8'd200};
    step(4'b0001, 1'b1, 4'b0001, 0, 300, 1'b1);
    step('0, 1'b1, '0, 0, 0, 1'b0);
    chk("add_a_reg", int'(add_a), 100);
    chk("add_b_reg", int'(add_b), 200);
    idle(3);

    // Carry and pointer wrap.
    a = {8'hFF, 8'd30, 8'd20, 8'd100};
    b = {8'hFF, 8'd3, 8'd2, 8'd200};
    step(4'b1000, 1'b1, 4'b1000, 3, 'h1FE, 1'b1);
    step(4'b1001, 1'b1, 4'b0001, 0, 300, 1'b1);
    step(4'b1000, 1'b1, 4'b1000, 3, 'h1FE, 1'b1);
    idle(4);

    // Enable gating: ptr=0, only requester 1 served before enable drops.
    step(4'b0110, 1'b1, 4'b0010, 1, 22, 1'b1);
    step(4'b0110, 1'b0, '0, 0, 0, 1'b0);
    chk("busy_inflight", int'(busy), 1);
    for (int k = 0; k < 3; k++) step(4'b0110, 1'b0, '0, 0, 0, 1'b0);
    chk("busy_drained", int'(busy), 0);
    step(4'b0110, 1'b0, '0, 0, 0, 1'b0);
    step(4'b0110, 1'b1, 4'b0100, 2, 33, 1'b1);
    idle(4);

    // Reset one cycle after a grant to requester 3 (ptr=3); no response may follow.
    step(4'b1111, 1'b1, 4'b1000, 0, 0, 1'b0);
    @(negedge clk);
    req = '0;
    rst = 1'b1;
    #1;
    check_zero("midrst");
    @(negedge clk);
    rst = 1'b0;
    idle(5);
    step(4'b1111, 1'b1, 4'b0001, 0, 300, 1'b1);
    idle(1);

    for (int k = 0; k < 20 && q.size() != 0; k++) @(negedge clk);
    chk("queue_drained", q.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
